// File: rtl/queue_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : queue_serial_pkg
//  Purpose  : Shared types and constants for the queue-to-serial transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package queue_serial_pkg;

  // Transmitter sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  // Serial line levels
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width able to hold 0..count-1, never narrower than one bit
  function automatic int counter_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage
`default_nettype wire

// File: rtl/queue_serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tx_bit_timer
//  Purpose  : Free-running bit-period counter for the serial transmitter.
//             Counts 0..CLKS_PER_BIT-1 while enabled (clear low) and flags
//             the last cycle of each bit period with bit_end.
//  Revision : 1.0  initial release
// ============================================================================
module tx_bit_timer
  import queue_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int                 CNT_W = counter_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last = (count == LAST);

  // Bit-period counter: held at zero while cleared, wraps after the last cycle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (at_last) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // With a single-cycle bit the counter never leaves zero, so every
  // enabled cycle is a bit end.
  assign bit_end = ~reset & ~clear & at_last;

endmodule
`default_nettype wire

// File: rtl/queue_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : queue_serial_tx
//  Purpose  : Drains bytes from a circular queue and sends each one as a
//             start bit, DATA_W data bits (LSB first) and a stop bit.
//             A new byte is popped only while idle, which back-pressures
//             the queue naturally.
//  Revision : 1.0  initial release
// ============================================================================
module queue_serial_tx
  import queue_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_enable,
  input  logic              q_empty,
  input  logic [DATA_W-1:0] q_data,
  output logic              q_dequeue,
  output logic              tx_serial,
  output logic              busy,
  output logic              byte_done
);

  localparam int                IDX_W    = counter_width(DATA_W);
  localparam logic [IDX_W-1:0]  LAST_BIT = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic              bit_end;
  logic              timer_clear;

  // The bit timer only runs while a frame is on the line
  assign timer_clear = (state == IDLE) || (state == FETCH);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .bit_end (bit_end)
  );

  // Pop request is combinational so the queue sees it in the same idle cycle
  assign q_dequeue = (state == IDLE) & tx_enable & ~q_empty & ~reset;

  // Completion pulse coincides with the final stop-bit cycle
  assign byte_done = (state == STOP) & bit_end;

  // Frame sequencer: outputs are loaded with the value of the next cycle so
  // the line level changes exactly on the state boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx_serial <= LINE_IDLE;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_serial <= LINE_IDLE;
          if (q_dequeue) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end

        FETCH: begin
          // Queue data is valid the cycle after the pop
          shift_reg <= q_data;
          bit_idx   <= '0;
          tx_serial <= START_BIT;
          state     <= START;
        end

        START: begin
          if (bit_end) begin
            tx_serial <= shift_reg[0];
            state     <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == LAST_BIT) begin
              tx_serial <= STOP_BIT;
              state     <= STOP;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx_serial <= shift_reg[1];
            end
          end
        end

        STOP: begin
          if (bit_end) begin
            tx_serial <= LINE_IDLE;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          tx_serial <= LINE_IDLE;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_queue_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_queue_serial_tx
//  Purpose  : Directed self-checking bench for queue_serial_tx (C=4 and C=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_queue_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en4;
  logic       en1;
  logic       q_empty;
  logic [7:0] q_data;
  logic       deq4, tx4, busy4, done4;
  logic       deq1, tx1, busy1, done1;

  // Simple queue model shared by both instances (only one is enabled at a time)
  logic [7:0] mem [0:15];
  int         rd = 0;
  int         wr = 0;

  assign q_empty = (rd == wr);

  always @(posedge clk) begin
    if (deq4 | deq1) begin
      q_data <= mem[rd[3:0]];
      rd     <= rd + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  queue_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .tx_enable (en4),
    .q_empty   (q_empty),
    .q_data    (q_data),
    .q_dequeue (deq4),
    .tx_serial (tx4),
    .busy      (busy4),
    .byte_done (done4)
  );

  queue_serial_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .tx_enable (en1),
    .q_empty   (q_empty),
    .q_data    (q_data),
    .q_dequeue (deq1),
    .tx_serial (tx1),
    .busy      (busy1),
    .byte_done (done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr[3:0]] = b;
    wr = wr + 1;
  endtask

  // Checks cycles 1..last_c of a frame whose dequeue happened in cycle 0
  task automatic frame(input int C, input logic [7:0] b, input int last_c,
                       input int drop_at, input string tag);
    logic e_tx, e_busy, e_done;
    logic o_tx, o_busy, o_done, o_deq;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk); #1;
      if (c == drop_at) en4 = 1'b0;
      #3;
      if (c < 2)                e_tx = 1'b1;
      else if (c <= 1 + C)      e_tx = 1'b0;
      else if (c <= 1 + 9 * C)  e_tx = b[(c - 2 - C) / C];
      else                      e_tx = 1'b1;
      e_busy = (c <= 1 + 10 * C);
      e_done = (c == 1 + 10 * C);
      o_tx   = (C == 1) ? tx1   : tx4;
      o_busy = (C == 1) ? busy1 : busy4;
      o_done = (C == 1) ? done1 : done4;
      o_deq  = (C == 1) ? deq1  : deq4;
      chk($sformatf("%s_tx_c%0d", tag, c),   32'(o_tx),   32'(e_tx));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(o_busy), 32'(e_busy));
      chk($sformatf("%s_done_c%0d", tag, c), 32'(o_done), 32'(e_done));
      chk($sformatf("%s_deq_c%0d", tag, c),  32'(o_deq),  32'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    en4   = 1'b0;
    en1   = 1'b0;
    push(8'hA5);

    // Reset state; pop must stay low under reset even with data and enable
    repeat (2) @(posedge clk);
    #1; en4 = 1'b1; #3;
    chk("rst_tx4",   32'(tx4),   32'd1);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_deq4",  32'(deq4),  32'd0);
    chk("rst_tx1",   32'(tx1),   32'd1);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_deq1",  32'(deq1),  32'd0);

    // Test 1: 0xA5, dequeue in cycle 0
    @(posedge clk); #1; reset = 1'b0; #3;
    chk("t1_deq_c0",  32'(deq4),  32'd1);
    chk("t1_tx_c0",   32'(tx4),   32'd1);
    chk("t1_busy_c0", 32'(busy4), 32'd0);
    frame(4, 8'hA5, 41, -1, "t1");

    // Test 2: empty queue, enabled, 50 cycles of idle line
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #4;
      chk($sformatf("t2_deq_k%0d", k),  32'(deq4),  32'd0);
      chk($sformatf("t2_tx_k%0d", k),   32'(tx4),   32'd1);
      chk($sformatf("t2_busy_k%0d", k), 32'(busy4), 32'd0);
    end

    // Test 3: back-to-back 0x01 then 0x80
    @(posedge clk); #1; push(8'h01); push(8'h80); #3;
    chk("t3_deq_c0", 32'(deq4), 32'd1);
    frame(4, 8'h01, 41, -1, "t3a");
    @(posedge clk); #4;
    chk("t3_deq_c42",  32'(deq4),  32'd1);
    chk("t3_tx_c42",   32'(tx4),   32'd1);
    chk("t3_busy_c42", 32'(busy4), 32'd0);
    frame(4, 8'h80, 41, -1, "t3b");
    @(posedge clk); #4;
    chk("t3_deq_c84", 32'(deq4), 32'd0);

    // Test 4: enable dropped at cycle 10 with a second byte waiting
    @(posedge clk); #1; push(8'h5A); push(8'hC3); #3;
    chk("t4_deq_c0", 32'(deq4), 32'd1);
    frame(4, 8'h5A, 41, 10, "t4");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #4;
      chk($sformatf("t4_post_deq_k%0d", k),  32'(deq4),  32'd0);
      chk($sformatf("t4_post_busy_k%0d", k), 32'(busy4), 32'd0);
    end

    // Test 5: reset in cycles 20-21 aborts the 0xC3 frame
    @(posedge clk); #1; push(8'h96); en4 = 1'b1; #3;
    chk("t5_deq_c0", 32'(deq4), 32'd1);
    frame(4, 8'hC3, 19, -1, "t5a");
    @(posedge clk); #1; reset = 1'b1; #3;
    chk("t5_tx_c20",   32'(tx4),   32'd0);
    chk("t5_deq_c20",  32'(deq4),  32'd0);
    chk("t5_done_c20", 32'(done4), 32'd0);
    @(posedge clk); #4;
    chk("t5_tx_c21",   32'(tx4),   32'd1);
    chk("t5_busy_c21", 32'(busy4), 32'd0);
    chk("t5_done_c21", 32'(done4), 32'd0);
    chk("t5_deq_c21",  32'(deq4),  32'd0);
    @(posedge clk); #1; reset = 1'b0; #3;
    chk("t5_tx_c22",   32'(tx4),   32'd1);
    chk("t5_busy_c22", 32'(busy4), 32'd0);
    chk("t5_done_c22", 32'(done4), 32'd0);
    chk("t5_deq_c22",  32'(deq4),  32'd1);
    frame(4, 8'h96, 41, -1, "t5b");

    // Test 6: one clock per bit, byte 0x3C
    @(posedge clk); #1; en4 = 1'b0; en1 = 1'b1; push(8'h3C); #3;
    chk("t6_deq1_c0", 32'(deq1), 32'd1);
    chk("t6_deq4_c0", 32'(deq4), 32'd0);
    frame(1, 8'h3C, 11, -1, "t6");
    @(posedge clk); #4;
    chk("t6_deq_c12",  32'(deq1),  32'd0);
    chk("t6_tx_c12",   32'(tx1),   32'd1);
    chk("t6_busy_c12", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
